tick_gen: RTL
=============

TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 The block SHALL have parameter CLK_PER_US, default 27, giving PLL output clock cycles per microsecond tick; legal range is 2 or more.
REQ-002 The block SHALL have parameter US_PER_MS, default 1000, giving microsecond ticks per millisecond tick; legal range is 2 or more.
REQ-003 The block SHALL have parameter MS_PER_S, default 1000, giving millisecond ticks per second tick; legal range is 2 or more.
REQ-004 The block SHALL have parameter SEC_W, default 32, giving the width of the seconds counter; legal range is 1 to 32.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, driven by the PLL clkout (27 MHz).
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit: count enable, sampled on every clk rising edge.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous clear of all counters and outputs.
REQ-009 The block SHALL have port tick_us, output, 1 bit: one-cycle pulse per microsecond.
REQ-010 The block SHALL have port tick_ms, output, 1 bit: one-cycle pulse per millisecond.
REQ-011 The block SHALL have port tick_s, output, 1 bit: one-cycle pulse per second.
REQ-012 The block SHALL have port sec_cnt, output, SEC_W bits: elapsed-seconds count.
REQ-013 The block SHALL have port led, output, 1 bit: toggles on every second tick.
REQ-014 Every output SHALL be driven directly from a register, with no combinational path from any input to any output.

Function
REQ-015 The block SHALL contain three cascaded counters: pre (0..CLK_PER_US-1), us (0..US_PER_MS-1) and ms (0..MS_PER_S-1).
REQ-016 On an edge with en=1 and clr=0, pre SHALL increment by 1, and SHALL wrap from CLK_PER_US-1 to 0.
REQ-017 tick_us SHALL be 1 for exactly the one cycle following an edge at which pre wraps, and 0 otherwise.
REQ-018 us SHALL advance only on an edge at which pre wraps, and SHALL wrap from US_PER_MS-1 to 0.
REQ-019 tick_ms SHALL be registered on the same edge as the us wrap, so that tick_ms is coincident with the tick_us of that wrap.
REQ-020 ms SHALL advance only on an edge at which us wraps, and SHALL wrap from MS_PER_S-1 to 0.
REQ-021 tick_s SHALL be coincident with the tick_ms and tick_us of an ms wrap.
REQ-022 sec_cnt SHALL increment by 1 on the same edge that sets tick_s, and SHALL wrap modulo 2^SEC_W from all-ones to 0.
REQ-023 led SHALL invert on the same edge that sets tick_s.
REQ-024 With en held at 1 after reset, the first tick_us SHALL appear after enabled edge CLK_PER_US, and the first tick_s after enabled edge CLK_PER_US*US_PER_MS*MS_PER_S.
REQ-025 On an edge with en=0, all counters, sec_cnt and led SHALL hold their values, and all tick outputs SHALL be 0 in the following cycle; counting SHALL resume from the held values with no lost or extra cycles.
REQ-026 On an edge with clr=1, pre, us and ms SHALL go to 0, sec_cnt SHALL go to 0, led SHALL go to 0 and all tick outputs SHALL go to 0, regardless of en.
REQ-027 When clr=1 coincides with a wrap, clr SHALL take priority, and no tick SHALL be generated.
REQ-028 Tick pulses SHALL never be wider than one cycle, including when en toggles every cycle.

Reset
REQ-029 rst SHALL take priority over clr and en.
REQ-030 On an edge with rst=1, all counters SHALL go to 0 and every output SHALL go to 0: tick_us=0, tick_ms=0, tick_s=0, sec_cnt=0, led=0.
REQ-031 A reset asserted mid-count SHALL discard partial counts, and counting SHALL restart from 0 on the first edge with rst=0.

Verification (CLK_PER_US=4, US_PER_MS=3, MS_PER_S=2, SEC_W=2 unless noted; edge numbering starts at the first edge with rst=0)
REQ-032 Scenario 1 (reset): rst=1 for 3 cycles with en=1 -> all outputs are 0 throughout, and tick_us first rises after edge 4.
REQ-033 Scenario 2 (cascade): en=1 continuous -> tick_us high after edges 4, 8, 12, ...; tick_ms high after edges 12 and 24; tick_s high after edge 24; after edge 24, sec_cnt=1 and led=1.
REQ-034 Scenario 3 (pause): en=1 for edges 1-2, en=0 for edges 3-7, en=1 thereafter -> first tick_us rises after edge 9, and all ticks stay 0 during the pause.
REQ-035 Scenario 4 (clr on wrap): clr=1 on edge 24 -> tick_s, tick_ms and tick_us are all 0 after edge 24, sec_cnt=0, led=0, and the next tick_us rises after edge 28.
REQ-036 Scenario 5 (wrap): en=1 for 96 edges -> sec_cnt reads 1, 2, 3, 0 after edges 24, 48, 72 and 96, and led reads 1, 0, 1, 0 at the same points.
REQ-037 Scenario 6 (default parameters): en=1 continuous -> tick_us period is exactly 27 cycles, and tick_ms period is exactly 27000 cycles.

Source files
------------

// File: rtl/tick_gen.sv
// ============================================================================
// Module   : tick_gen
// Purpose  : Cascaded prescaler producing one-cycle us/ms/s ticks, a seconds
//            counter and a 1 Hz-toggling LED, all driven straight from flops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int CLK_PER_US = 27,
  parameter int US_PER_MS  = 1000,
  parameter int MS_PER_S   = 1000,
  parameter int SEC_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic             tick_us,
  output logic             tick_ms,
  output logic             tick_s,
  output logic [SEC_W-1:0] sec_cnt,
  output logic             led
);

  localparam int c_pre_w = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int c_us_w  = (US_PER_MS  > 1) ? $clog2(US_PER_MS)  : 1;
  localparam int c_ms_w  = (MS_PER_S   > 1) ? $clog2(MS_PER_S)   : 1;

  localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(CLK_PER_US - 1);
  localparam logic [c_us_w-1:0]  c_us_max  = c_us_w'(US_PER_MS - 1);
  localparam logic [c_ms_w-1:0]  c_ms_max  = c_ms_w'(MS_PER_S - 1);

  logic [c_pre_w-1:0] r_pre;
  logic [c_us_w-1:0]  r_us;
  logic [c_ms_w-1:0]  r_ms;
  logic [SEC_W-1:0]   r_sec;
  logic               r_led;
  logic               r_tick_us;
  logic               r_tick_ms;
  logic               r_tick_s;

  logic w_pre_wrap;
  logic w_us_wrap;
  logic w_ms_wrap;

  // Each wrap qualifies the next stage, so coincident ticks share one edge.
  assign w_pre_wrap = (r_pre == c_pre_max);
  assign w_us_wrap  = w_pre_wrap && (r_us == c_us_max);
  assign w_ms_wrap  = w_us_wrap  && (r_ms == c_ms_max);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_pre     <= '0;
      r_us      <= '0;
      r_ms      <= '0;
      r_sec     <= '0;
      r_led     <= 1'b0;
      r_tick_us <= 1'b0;
      r_tick_ms <= 1'b0;
      r_tick_s  <= 1'b0;
    end else if (en) begin
      r_tick_us <= w_pre_wrap;
      r_tick_ms <= w_us_wrap;
      r_tick_s  <= w_ms_wrap;

      r_pre <= w_pre_wrap ? '0 : r_pre + c_pre_w'(1);
      if (w_pre_wrap) begin
        r_us <= w_us_wrap ? '0 : r_us + c_us_w'(1);
      end
      if (w_us_wrap) begin
        r_ms <= w_ms_wrap ? '0 : r_ms + c_ms_w'(1);
      end
      if (w_ms_wrap) begin
        r_sec <= r_sec + SEC_W'(1);
        r_led <= ~r_led;
      end
    end else begin
      // Paused: counts hold, and ticks drop so no pulse can stretch.
      r_tick_us <= 1'b0;
      r_tick_ms <= 1'b0;
      r_tick_s  <= 1'b0;
    end
  end

  assign tick_us = r_tick_us;
  assign tick_ms = r_tick_ms;
  assign tick_s  = r_tick_s;
  assign sec_cnt = r_sec;
  assign led     = r_led;

endmodule

`default_nettype wire
